// File: rtl/alu_issue_stage.sv
// alu_issue_stage: operand-issue stage ahead of the 8-bit ALU, with a one-bubble RAW interlock
// on the r/s feedback path plus issue and stall debug counters.
package instr_pack;
    typedef enum logic [3:0] {ADD, SUB, AND, ORR, EOR, FLP, REVx, REVy, PARx, PARy} math;
endpackage

module alu_issue_stage
    import instr_pack::*;
#(
    parameter int DW = 8,
    parameter int RA = 3,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  math           in_op,
    input  logic          in_dst,
    input  logic [1:0]    in_xsel,
    input  logic [1:0]    in_ysel,
    input  logic [RA-1:0] in_xa,
    input  logic [RA-1:0] in_ya,
    input  logic [DW-1:0] in_imm,
    output logic [RA-1:0] rf_xa,
    output logic [RA-1:0] rf_ya,
    input  logic [DW-1:0] rf_xd,
    input  logic [DW-1:0] rf_yd,
    input  logic [DW-1:0] r_fb,
    input  logic [DW-1:0] s_fb,
    input  logic          flush,
    output logic [DW-1:0] x,
    output logic [DW-1:0] y,
    output math           math_op,
    output logic          alu_en,
    output logic          alu_rs,
    output logic          stall,
    output logic [CW-1:0] issue_cnt,
    output logic [CW-1:0] stall_cnt
);
    logic [1:0]    fb_sel;
    logic          x_dep, y_dep, accept;
    logic [DW-1:0] x_mux, y_mux;

    assign rf_xa = in_xa;
    assign rf_ya = in_ya;

    // fb_sel is the select code that would read the register the in-flight op is writing
    always_comb begin
        fb_sel   = alu_rs ? 2'd2 : 2'd1;
        x_dep    = (in_xsel == fb_sel) && !(in_op inside {REVy, PARy});
        y_dep    = (in_ysel == fb_sel) && !(in_op inside {FLP, REVx, PARx});
        stall    = alu_en && in_valid && (x_dep || y_dep);
        in_ready = !flush && !stall;
        accept   = in_valid && in_ready;
        x_mux    = in_xsel == 2'd0 ? rf_xd : in_xsel == 2'd1 ? r_fb : in_xsel == 2'd2 ? s_fb : in_imm;
        y_mux    = in_ysel == 2'd0 ? rf_yd : in_ysel == 2'd1 ? r_fb : in_ysel == 2'd2 ? s_fb : in_imm;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x         <= '0;
            y         <= '0;
            math_op   <= ADD;
            alu_rs    <= 1'b0;
            alu_en    <= 1'b0;
            issue_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            alu_en <= accept;
            if (accept) begin
                x         <= x_mux;
                y         <= y_mux;
                math_op   <= in_op;
                alu_rs    <= in_dst;
                issue_cnt <= issue_cnt + 1'b1;
            end
            if (stall && !flush)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed vector table, reset/wrap sequences and a randomized run
// against a behavioural model of the issue stage, with a small ALU stub driving r/s feedback.
module tb_alu_issue_stage;
    import instr_pack::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0, in_ready, in_dst = 1'b0, flush = 1'b0;
    math        in_op = ADD;
    logic [1:0] in_xsel = 2'd0, in_ysel = 2'd0;
    logic [2:0] in_xa = 3'd0, in_ya = 3'd0, rf_xa, rf_ya;
    logic [7:0] in_imm = 8'd0, rf_xd, rf_yd, r_fb = 8'd0, s_fb = 8'd0, x, y;
    math        math_op;
    logic       alu_en, alu_rs, stall;
    logic [15:0] issue_cnt, stall_cnt;
    logic [7:0] rf [8];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign rf_xd = rf[rf_xa];
    assign rf_yd = rf[rf_ya];

    alu_issue_stage #(.DW(8), .RA(3), .CW(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_dst(in_dst), .in_xsel(in_xsel), .in_ysel(in_ysel), .in_xa(in_xa), .in_ya(in_ya),
        .in_imm(in_imm), .rf_xa(rf_xa), .rf_ya(rf_ya), .rf_xd(rf_xd), .rf_yd(rf_yd),
        .r_fb(r_fb), .s_fb(s_fb), .flush(flush), .x(x), .y(y), .math_op(math_op),
        .alu_en(alu_en), .alu_rs(alu_rs), .stall(stall), .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic v, f;
        math op;
        logic d;
        logic [1:0] xs, ys;
        logic [2:0] xa, ya;
        logic [7:0] imm;
        logic e_stall, e_ready, e_en;
        logic [7:0] e_x, e_y;
    } vec_t;

    vec_t tv [9];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] alu_f(math op, logic [7:0] a, logic [7:0] b);
        case (op)
            ADD:     return a + b;
            SUB:     return a - b;
            EOR:     return a ^ b;
            default: return ~a;
        endcase
    endfunction

    task automatic drive(logic v, logic f, math op, logic d, logic [1:0] xs, logic [1:0] ys,
                         logic [2:0] xa, logic [2:0] ya, logic [7:0] imm);
        in_valid = v; flush = f; in_op = op; in_dst = d;
        in_xsel = xs; in_ysel = ys; in_xa = xa; in_ya = ya; in_imm = imm;
    endtask

    // ALU stub: the result of an issued op lands in r or s during its issue cycle
    task automatic tick();
        @(posedge clk);
        #1;
        if (alu_en) begin
            if (alu_rs) s_fb = alu_f(math_op, x, y);
            else        r_fb = alu_f(math_op, x, y);
        end
    endtask

    function automatic logic [7:0] pick(logic [1:0] sel, logic [2:0] a, logic [7:0] imm);
        case (sel)
            2'd0:    return rf[a];
            2'd1:    return r_fb;
            2'd2:    return s_fb;
            default: return imm;
        endcase
    endfunction

    logic [7:0] m_x, m_y;
    math        m_op;
    logic       m_rs, m_en;
    logic [15:0] m_issue, m_stall;

    initial begin
        rf = '{8'hA0, 8'h31, 8'h42, 8'h12, 8'h03, 8'h55, 8'h66, 8'h77};
        tv[0] = '{1'b1, 1'b0, ADD, 1'b0, 2'd0, 2'd3, 3'd3, 3'd0, 8'h05, 1'b0, 1'b1, 1'b1, 8'h12, 8'h05};
        tv[1] = '{1'b1, 1'b0, EOR, 1'b1, 2'd0, 2'd0, 3'd1, 3'd2, 8'h00, 1'b0, 1'b1, 1'b1, 8'h31, 8'h42};
        tv[2] = '{1'b1, 1'b0, ADD, 1'b0, 2'd0, 2'd3, 3'd4, 3'd0, 8'h04, 1'b0, 1'b1, 1'b1, 8'h03, 8'h04};
        tv[3] = '{1'b1, 1'b0, SUB, 1'b0, 2'd1, 2'd3, 3'd0, 3'd0, 8'h01, 1'b1, 1'b0, 1'b0, 8'h03, 8'h04};
        tv[4] = '{1'b1, 1'b0, SUB, 1'b0, 2'd1, 2'd3, 3'd0, 3'd0, 8'h01, 1'b0, 1'b1, 1'b1, 8'h07, 8'h01};
        tv[5] = '{1'b1, 1'b0, ADD, 1'b1, 2'd0, 2'd3, 3'd0, 3'd0, 8'h10, 1'b0, 1'b1, 1'b1, 8'hA0, 8'h10};
        tv[6] = '{1'b1, 1'b0, FLP, 1'b0, 2'd0, 2'd2, 3'd0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA0, 8'hB0};
        tv[7] = '{1'b1, 1'b1, SUB, 1'b0, 2'd1, 2'd3, 3'd0, 3'd0, 8'h01, 1'b1, 1'b0, 1'b0, 8'hA0, 8'hB0};
        tv[8] = '{1'b1, 1'b0, SUB, 1'b0, 2'd1, 2'd3, 3'd0, 3'd0, 8'h01, 1'b0, 1'b1, 1'b1, 8'h5F, 8'h01};

        #12;
        chk("rst_en", alu_en, 0);
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_op", math_op, ADD);
        chk("rst_rs", alu_rs, 0);
        chk("rst_icnt", issue_cnt, 0);
        chk("rst_scnt", stall_cnt, 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) begin
            drive(tv[i].v, tv[i].f, tv[i].op, tv[i].d, tv[i].xs, tv[i].ys, tv[i].xa, tv[i].ya, tv[i].imm);
            #1;
            chk($sformatf("v%0d_stall", i), stall, tv[i].e_stall);
            chk($sformatf("v%0d_ready", i), in_ready, tv[i].e_ready);
            chk($sformatf("v%0d_rfxa", i), rf_xa, tv[i].xa);
            tick();
            chk($sformatf("v%0d_en", i), alu_en, tv[i].e_en);
            chk($sformatf("v%0d_x", i), x, tv[i].e_x);
            chk($sformatf("v%0d_y", i), y, tv[i].e_y);
        end
        chk("tbl_icnt", issue_cnt, 7);
        chk("tbl_scnt", stall_cnt, 1);
        chk("tbl_op", math_op, SUB);
        chk("tbl_rs", alu_rs, 0);

        // asynchronous reset in the middle of an issue cycle
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_en", alu_en, 0);
        chk("mid_rst_x", x, 0);
        chk("mid_rst_y", y, 0);
        chk("mid_rst_op", math_op, ADD);
        chk("mid_rst_icnt", issue_cnt, 0);
        chk("mid_rst_scnt", stall_cnt, 0);
        #2;
        reset = 1'b0;

        drive(1'b1, 1'b0, ADD, 1'b0, 2'd3, 2'd3, 3'd0, 3'd0, 8'h09);
        repeat (65536) tick();
        chk("wrap_icnt", issue_cnt, 0);
        chk("wrap_scnt", stall_cnt, 0);
        chk("wrap_en", alu_en, 1);
        chk("wrap_x", x, 8'h09);

        drive(1'b0, 1'b0, ADD, 1'b0, 2'd0, 2'd0, 3'd0, 3'd0, 8'h00);
        reset = 1'b1;
        #3;
        reset = 1'b0;
        m_x = 0; m_y = 0; m_op = ADD; m_rs = 0; m_en = 0; m_issue = 0; m_stall = 0;
        for (int i = 0; i < 400; i++) begin
            logic v, f, d, hz, xu, yu;
            logic [1:0] xs, ys;
            logic [2:0] xa, ya;
            logic [7:0] imm, vx, vy;
            math op;
            v = ($urandom_range(0, 9) < 8);
            f = ($urandom_range(0, 9) == 0);
            op = math'($urandom_range(0, 9));
            d = 1'($urandom);
            xs = 2'($urandom); ys = 2'($urandom);
            xa = 3'($urandom); ya = 3'($urandom);
            imm = 8'($urandom);
            if (i % 7 == 0) rf[$urandom_range(0, 7)] = 8'($urandom);
            drive(v, f, op, d, xs, ys, xa, ya, imm);
            #1;
            // an operand depends on the in-flight op if it reads the register that op writes
            xu = !(op inside {REVy, PARy});
            yu = !(op inside {FLP, REVx, PARx});
            hz = m_en && v && ((xu && xs == (m_rs ? 2'd2 : 2'd1)) || (yu && ys == (m_rs ? 2'd2 : 2'd1)));
            vx = pick(xs, xa, imm);
            vy = pick(ys, ya, imm);
            chk("rnd_stall", stall, hz);
            chk("rnd_ready", in_ready, !f && !hz);
            chk("rnd_rfya", rf_ya, ya);
            tick();
            if (v && !f && !hz) begin
                m_x = vx; m_y = vy; m_op = op; m_rs = d; m_en = 1; m_issue++;
            end else
                m_en = 0;
            if (hz && !f) m_stall++;
            chk("rnd_en", alu_en, m_en);
            chk("rnd_x", x, m_x);
            chk("rnd_y", y, m_y);
            chk("rnd_op", math_op, m_op);
            chk("rnd_rs", alu_rs, m_rs);
            chk("rnd_icnt", issue_cnt, m_issue);
            chk("rnd_scnt", stall_cnt, m_stall);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
